// File: rtl/shift_pkg.sv
// shift_pkg: shared constants, opcode encoding and amount helper for the shift unit.
package shift_pkg;
   localparam int WIDTH = 16;
   localparam int AMTW  = 4;

   typedef enum logic [1:0] {
      OP_ROL = 2'b00,
      OP_SLL = 2'b01,
      OP_ROR = 2'b10,
      OP_SRL = 2'b11
   } shift_op_e;

   // Left shifts become right rotates by (WIDTH - amt) mod WIDTH.
   function automatic logic [AMTW-1:0] neg_amt(input logic [AMTW-1:0] amt);
      return AMTW'(WIDTH - int'(amt));
   endfunction
endpackage

// File: rtl/shift_amt_prep.sv
// shift_amt_prep: maps opcode and amount onto a right-rotate amount and a zero mask.
module shift_amt_prep
   import shift_pkg::*;
(
   input  logic [1:0]       op_i,
   input  logic [AMTW-1:0]  amt_i,
   output logic [AMTW-1:0]  r_o,
   output logic [WIDTH-1:0] m_o
);
   localparam logic [WIDTH-1:0] ONES = '1;

   always_comb begin
      r_o = (op_i == OP_ROR || op_i == OP_SRL) ? amt_i : neg_amt(amt_i);
      m_o = op_i == OP_SLL ? ONES << amt_i : op_i == OP_SRL ? ONES >> amt_i : ONES;
   end
endmodule

// File: rtl/shift_ex_unit.sv
// shift_ex_unit: two-stage pipelined shift/rotate unit for the execute stage.
// Stage 1 registers operand, rotate amount and mask; stage 2 rotates, masks and drives EX/MEM.
module shift_ex_unit #(
   parameter int WIDTH = 16,
   parameter int TAGW  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [3:0]       in_amt,
   input  logic [1:0]       in_op,
   input  logic [TAGW-1:0]  in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAGW-1:0]  out_tag
);
   import shift_pkg::*;

   logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s1_data_q, s1_data_d, s1_m_q, s1_m_d, out_data_q, out_data_d;
   logic [3:0]       s1_r_q, s1_r_d, prep_r;
   logic [TAGW-1:0]  s1_tag_q, s1_tag_d, out_tag_q, out_tag_d;
   logic [WIDTH-1:0] prep_m, rot1, rot2, rot4, rot8;
   logic             s1_adv, s2_adv, accept, s2_load;

   shift_amt_prep u_prep (
      .op_i  (in_op),
      .amt_i (in_amt),
      .r_o   (prep_r),
      .m_o   (prep_m)
   );

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv && !flush;
   assign accept   = in_valid && in_ready;
   assign s2_load  = s1_valid_q && s2_adv;

   assign rot1 = s1_r_q[0] ? {s1_data_q[0],   s1_data_q[WIDTH-1:1]} : s1_data_q;
   assign rot2 = s1_r_q[1] ? {rot1[1:0],      rot1[WIDTH-1:2]}      : rot1;
   assign rot4 = s1_r_q[2] ? {rot2[3:0],      rot2[WIDTH-1:4]}      : rot2;
   assign rot8 = s1_r_q[3] ? {rot4[7:0],      rot4[WIDTH-1:8]}      : rot4;

   // Flush wins over every advance; stage-2 data only moves when it is overwritable.
   always_comb begin
      s1_valid_d = flush ? 1'b0 : s1_adv ? accept : s1_valid_q;
      s2_valid_d = flush ? 1'b0 : s2_adv ? s1_valid_q : s2_valid_q;
      s1_data_d  = accept ? in_data : s1_data_q;
      s1_tag_d   = accept ? in_tag  : s1_tag_q;
      s1_r_d     = accept ? prep_r  : s1_r_q;
      s1_m_d     = accept ? prep_m  : s1_m_q;
      out_data_d = s2_load ? rot8 & s1_m_q : out_data_q;
      out_tag_d  = s2_load ? s1_tag_q : out_tag_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_tag_q   <= '0;
         s1_r_q     <= '0;
         s1_m_q     <= '0;
         out_data_q <= '0;
         out_tag_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_data_q  <= s1_data_d;
         s1_tag_q   <= s1_tag_d;
         s1_r_q     <= s1_r_d;
         s1_m_q     <= s1_m_d;
         out_data_q <= out_data_d;
         out_tag_q  <= out_tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_shift_ex_unit.sv
// tb_shift_ex_unit: table vectors, handshake corner sequences and random traffic
// checked against an arithmetic shift model and an in-order tag scoreboard.
module tb_shift_ex_unit;
   import shift_pkg::*;

   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
   logic [15:0] in_data = '0, out_data;
   logic [3:0]  in_amt = '0;
   logic [1:0]  in_op = '0;
   logic [2:0]  in_tag = '0, out_tag;

   shift_ex_unit #(.WIDTH(16), .TAGW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  amt;
      logic [15:0] d;
      logic [2:0]  tag;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] d;
      logic [2:0]  tag;
      int          acc;
   } exp_t;

   vec_t tbl[12];
   exp_t q[$];
   int   n_vec = 0, n_err = 0, cyc = 0;

   function automatic logic [15:0] ref_shift(input logic [1:0] op, input int a, input logic [15:0] d);
      int unsigned x = d;
      case (op)
         2'b00:   return 16'((x << a) | (x >> (16 - a)));
         2'b01:   return 16'(x << a);
         2'b10:   return 16'((x >> a) | (x << (16 - a)));
         default: return 16'(x >> a);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One cycle: apply inputs, check handshake and outputs against the model, then clock.
   task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] amt,
                        input logic [15:0] d, input logic [2:0] tag, input logic ordy,
                        input logic fl, input logic [15:0] e);
      in_valid = v; in_op = op; in_amt = amt; in_data = d; in_tag = tag;
      out_ready = ordy; flush = fl;
      #1;
      chk("in_ready", 32'(in_ready), 32'(!fl && !(q.size() == 2 && !ordy)));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0 && cyc >= q[0].acc + 2));
      if (out_valid && q.size() > 0) begin
         chk("out_data", 32'(out_data), 32'(q[0].d));
         chk("out_tag", 32'(out_tag), 32'(q[0].tag));
         if (ordy) void'(q.pop_front());
      end
      if (fl) q.delete();
      else if (v && in_ready) q.push_back('{e, tag, cyc});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 2'b00, 4'd0, 16'h0000, 3'd0, ordy, 1'b0, 16'h0000);
   endtask

   task automatic issue(input vec_t t, input logic ordy);
      drive(1'b1, t.op, t.amt, t.d, t.tag, ordy, 1'b0, t.exp);
   endtask

   initial begin
      tbl[0]  = '{OP_ROL, 4'd1,  16'h8001, 3'd1, 16'h0003};
      tbl[1]  = '{OP_SLL, 4'd4,  16'h00FF, 3'd2, 16'h0FF0};
      tbl[2]  = '{OP_ROR, 4'd4,  16'h0001, 3'd3, 16'h1000};
      tbl[3]  = '{OP_SRL, 4'd15, 16'h8000, 3'd4, 16'h0001};
      tbl[4]  = '{OP_ROL, 4'd0,  16'hA5C3, 3'd5, 16'hA5C3};
      tbl[5]  = '{OP_SLL, 4'd0,  16'hA5C3, 3'd6, 16'hA5C3};
      tbl[6]  = '{OP_ROR, 4'd0,  16'hA5C3, 3'd7, 16'hA5C3};
      tbl[7]  = '{OP_SRL, 4'd0,  16'hA5C3, 3'd0, 16'hA5C3};
      tbl[8]  = '{OP_SLL, 4'd15, 16'h8001, 3'd1, 16'h8000};
      tbl[9]  = '{OP_SRL, 4'd1,  16'hFFFF, 3'd2, 16'h7FFF};
      tbl[10] = '{OP_ROL, 4'd8,  16'h1234, 3'd3, 16'h3412};
      tbl[11] = '{OP_ROR, 4'd12, 16'h1234, 3'd4, 16'h2341};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h0000);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      foreach (tbl[i]) issue(tbl[i], 1'b1);
      repeat (3) idle(1'b1);

      // Backpressure: two bundles fill the pipe, the third waits for out_ready.
      drive(1'b1, OP_ROR, 4'd1, 16'h00F0, 3'd1, 1'b0, 1'b0, 16'h0078);
      drive(1'b1, OP_SLL, 4'd2, 16'h0101, 3'd2, 1'b0, 1'b0, 16'h0404);
      repeat (3) drive(1'b1, OP_SRL, 4'd3, 16'h8000, 3'd3, 1'b0, 1'b0, 16'h1000);
      drive(1'b1, OP_SRL, 4'd3, 16'h8000, 3'd3, 1'b1, 1'b0, 16'h1000);
      repeat (3) idle(1'b1);
      chk("bp_drained", q.size(), 0);

      // Flush with two bundles in flight and a third offered.
      drive(1'b1, OP_ROL, 4'd3, 16'h1111, 3'd4, 1'b0, 1'b0, 16'h8888);
      drive(1'b1, OP_ROR, 4'd5, 16'h2222, 3'd5, 1'b0, 1'b0, 16'h1111);
      drive(1'b1, OP_SLL, 4'd1, 16'h3333, 3'd6, 1'b0, 1'b1, 16'h6666);
      repeat (3) idle(1'b1);

      // Asynchronous reset mid-stream.
      drive(1'b1, OP_SLL, 4'd7, 16'h00FF, 3'd2, 1'b0, 1'b0, 16'h7F80);
      drive(1'b1, OP_SRL, 4'd2, 16'hF000, 3'd3, 1'b0, 1'b0, 16'h3C00);
      idle(1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_data", 32'(out_data), 32'h0000);
      chk("arst_out_tag", 32'(out_tag), 32'd0);
      q.delete();
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      issue(tbl[0], 1'b1);
      repeat (3) idle(1'b1);
      chk("post_rst_drained", q.size(), 0);

      for (int i = 0; i < 10000; i++) begin
         logic [1:0]  op;
         logic [3:0]  amt;
         logic [15:0] d;
         op  = 2'($urandom);
         amt = 4'($urandom);
         d   = 16'($urandom);
         drive($urandom_range(0, 3) != 0, op, amt, d, 3'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
               ref_shift(op, int'(amt), d));
      end
      repeat (4) idle(1'b1);
      chk("final_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
